// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//   Two-port arbiter in front of the single-port data memory. Port 0 is the
//   CPU load/store unit, port 1 the DMA/debug master. The memory reads
//   combinationally and writes a whole word synchronously, so byte/halfword
//   stores are performed as read-modify-write. Each transaction ends with a
//   one-cycle ack to its owner.
//
//   Transaction flow: IDLE (grant) -> XFER -> [WB] -> RESP -> IDLE
//     read / full write / be=0 write : ack two cycles after the grant
//     partial write                  : ack three cycles after the grant
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req*/we*/addr*/be*/wdata*   request fields, held until the matching ack
//   ack0, ack1          one-cycle completion pulses
//   rdata0, rdata1      read data (shared register), valid with the ack
//   mem_addr/mem_din/mem_we     memory write side and word index
//   mem_dout            memory combinational read data
//
// Configuration
//   DM_ARB_FIXED_PRIO_EN  defined  : port 0 always wins contention
//                         undefined: round-robin between the two ports
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            we0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW/8-1:0] be0,
  input  logic [DW-1:0]   wdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW/8-1:0] be1,
  input  logic [DW-1:0]   wdata1,
  output logic            ack0,
  output logic [DW-1:0]   rdata0,
  output logic            ack1,
  output logic [DW-1:0]   rdata1,
  output logic [AW-3:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_dout
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_WB,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q;
  logic            we_q;
  logic [AW-3:0]   addr_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   merge_q, merge_d;
  logic [DW-1:0]   rdata_q;

  logic            any_req;
  logic            grant1;      // 1 = port 1 wins this grant
  logic            be_full;
  logic            be_none;

  // Byte-offset bits never reach the memory; the word index is all it sees.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

  assign any_req = req0 | req1;
  assign be_full = (be_q == {BW{1'b1}});
  assign be_none = (be_q == {BW{1'b0}});

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef DM_ARB_FIXED_PRIO_EN
  assign grant1 = req1 & ~req0;
`else
  logic last_grant_q;

  // On contention the port that did not win last time is served.
  assign grant1 = req1 & (~req0 | ~last_grant_q);

  // Reset to 1 so port 0 wins the very first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (state_q == S_IDLE && any_req) begin
      last_grant_q <= grant1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output is assigned a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (any_req) state_d = S_XFER;
      S_XFER: begin
        // Reads, full-word writes and empty-mask writes finish here; only a
        // genuine partial write needs the merge/write-back cycle.
        if (we_q && !be_full && !be_none) state_d = S_WB;
        else                              state_d = S_RESP;
      end
      S_WB:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from state so reset forces them inactive at once)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we  = 1'b0;
    mem_din = wdata_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    unique case (state_q)
      S_XFER: mem_we = we_q & be_full;
      S_WB: begin
        mem_we  = 1'b1;
        mem_din = merge_q;
      end
      S_RESP: begin
        ack0 = ~owner_q;
        ack1 = owner_q;
      end
      default: ;
    endcase
  end

  assign mem_addr = addr_q;
  assign rdata0   = rdata_q;
  assign rdata1   = rdata_q;

  // Lane merge for read-modify-write: enabled lanes from the store data,
  // the rest from the current memory word.
  always_comb begin
    merge_d = merge_q;
    for (int i = 0; i < BW; i++) begin
      merge_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_dout[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch and data registers
  // ---------------------------------------------------------------------------
  // Fields are captured only at the grant; later changes on the request
  // inputs do not affect the transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= grant1;
            we_q    <= grant1 ? we1 : we0;
            addr_q  <= grant1 ? addr1[AW-1:2] : addr0[AW-1:2];
            be_q    <= grant1 ? be1 : be0;
            wdata_q <= grant1 ? wdata1 : wdata0;
          end
        end
        S_XFER: begin
          if (!we_q)                      rdata_q <= mem_dout;
          else if (!be_full && !be_none)  merge_q <= merge_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//   Directed bench for dm_arbiter with a behavioural 1K-word data memory
//   (combinational read, synchronous word write). Inputs are driven and
//   outputs sampled on the falling edge; "cycle n" counts rising edges after
//   the cycle in which the request was first presented (the grant cycle).
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic            req0, we0, req1, we1;
  logic [AW-1:0]   addr0, addr1;
  logic [3:0]      be0, be1;
  logic [DW-1:0]   wdata0, wdata1;
  logic            ack0, ack1;
  logic [DW-1:0]   rdata0, rdata1;
  logic [AW-3:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic            mem_we;
  logic [DW-1:0]   mem_dout;

  logic [DW-1:0]   tb_mem [1024];

  int n_checks = 0;
  int n_pass   = 0;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .be0      (be0),
    .wdata0   (wdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .be1      (be1),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .rdata0   (rdata0),
    .ack1     (ack1),
    .rdata1   (rdata1),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory.
  assign mem_dout = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One transaction on port p; waits (bounded) for its ack, then drops req.
  // lat = cycle of the ack (0 if it never came), we_cnt/we_cyc describe the
  // memory write pulses seen, other = the wrong port acked meanwhile.
  task automatic txn(input bit p, input bit w, input logic [AW-1:0] a,
                     input logic [3:0] b, input logic [31:0] d,
                     output int lat, output int we_cnt, output int we_cyc,
                     output logic [31:0] rd, output bit other);
    lat = 0; we_cnt = 0; we_cyc = 0; rd = '0; other = 1'b0;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; be1 = b; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; be0 = b; wdata0 = d; end
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (mem_we) begin we_cnt++; we_cyc = n; end
      if (p ? ack0 : ack1) other = 1'b1;
      if (p ? ack1 : ack0) begin
        lat = n;
        rd  = p ? rdata1 : rdata0;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    cyc();
  endtask

  int          lat, we_cnt, we_cyc;
  logic [31:0] rd;
  bit          other;
  int          na;
  bit          ack_port [4];
  int          ack_cyc  [4];
  bit          both_acks;

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;
    tb_mem[4]  = 32'hDEADBEEF;   // 0x010
    tb_mem[8]  = 32'hCAFEF00D;   // 0x020
    tb_mem[12] = 32'h11223344;   // 0x030
    tb_mem[16] = 32'h55667788;   // 0x040

    // ---- 1. reset with both ports requesting reads -------------------------
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010; be0 = 4'h0; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h020; be1 = 4'h0; wdata1 = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_ack0", {31'b0, ack0}, 32'd0);
      check("rst_ack1", {31'b0, ack1}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    end
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    rst_n = 1'b1;
    cyc();                                               // cycle 1
    check("first_grant_addr", {22'b0, mem_addr}, 32'd4);
    check("first_grant_ack0_c1", {31'b0, ack0}, 32'd0);
    cyc();                                               // cycle 2
    check("first_grant_ack0", {31'b0, ack0}, 32'd1);
    check("first_grant_ack1", {31'b0, ack1}, 32'd0);
    check("first_grant_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0; req1 = 1'b0;
    cyc();

    // ---- 2. port 0 read, cycle by cycle -----------------------------------
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    cyc();
    check("rd_addr_c1", {22'b0, mem_addr}, 32'd4);
    check("rd_we_c1", {31'b0, mem_we}, 32'd0);
    check("rd_ack0_c1", {31'b0, ack0}, 32'd0);
    cyc();
    check("rd_ack0_c2", {31'b0, ack0}, 32'd1);
    check("rd_ack1_c2", {31'b0, ack1}, 32'd0);
    check("rd_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0;
    cyc();
    check("rd_ack0_c3", {31'b0, ack0}, 32'd0);

    // ---- 3. port 1 full-word write ----------------------------------------
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h020; be1 = 4'hF; wdata1 = 32'h12345678;
    cyc();
    check("fw_we_c1", {31'b0, mem_we}, 32'd1);
    check("fw_addr_c1", {22'b0, mem_addr}, 32'd8);
    check("fw_din_c1", mem_din, 32'h12345678);
    cyc();
    check("fw_we_c2", {31'b0, mem_we}, 32'd0);
    check("fw_ack1_c2", {31'b0, ack1}, 32'd1);
    check("fw_ack0_c2", {31'b0, ack0}, 32'd0);
    req1 = 1'b0;
    cyc();
    txn(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, lat, we_cnt, we_cyc, rd, other);
    check("fw_readback", rd, 32'h12345678);
    check("fw_readback_lat", lat, 32'd2);

    // ---- 4. partial writes -------------------------------------------------
    txn(1'b0, 1'b1, 12'h030, 4'b0010, 32'h0000AB00, lat, we_cnt, we_cyc, rd, other);
    check("pw_lat", lat, 32'd3);
    check("pw_we_cnt", we_cnt, 32'd1);
    check("pw_we_cyc", we_cyc, 32'd2);
    check("pw_word", tb_mem[12], 32'h1122AB44);
    check("pw_other_ack", {31'b0, other}, 32'd0);

    txn(1'b0, 1'b1, 12'h030, 4'b0000, 32'hFFFFFFFF, lat, we_cnt, we_cyc, rd, other);
    check("be0_lat", lat, 32'd2);
    check("be0_we_cnt", we_cnt, 32'd0);
    check("be0_word", tb_mem[12], 32'h1122AB44);

    txn(1'b1, 1'b1, 12'h030, 4'b1001, 32'hAA0000BB, lat, we_cnt, we_cyc, rd, other);
    check("pw2_lat", lat, 32'd3);
    check("pw2_word", tb_mem[12], 32'hAA22ABBB);

    // ---- 5. contention, both held continuously -----------------------------
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h020;
    na = 0;
    both_acks = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (ack0 && ack1) both_acks = 1'b1;
      if ((ack0 || ack1) && na < 4) begin
        ack_port[na] = ack1;
        ack_cyc[na]  = k;
        na++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    check("cont_ack_count", na, 32'd4);
    check("cont_both_acks", {31'b0, both_acks}, 32'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef DM_ARB_FIXED_PRIO_EN
      check($sformatf("cont_port_%0d", i), {31'b0, ack_port[i]}, 32'd0);
`else
      check($sformatf("cont_port_%0d", i), {31'b0, ack_port[i]}, i % 2);
`endif
      check($sformatf("cont_cyc_%0d", i), ack_cyc[i], 2 + 3 * i);
    end

    // ---- 6. reset during write-back of a partial write ---------------------
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h040; be1 = 4'b0100; wdata1 = 32'h00990000;
    cyc();                                               // XFER
    cyc();                                               // WB
    check("mid_we_in_wb", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_we_dropped", {31'b0, mem_we}, 32'd0);
    other = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (ack0 || ack1 || mem_we) other = 1'b1;
    end
    check("mid_no_ack", {31'b0, other}, 32'd0);
    check("mid_word_kept", tb_mem[16], 32'h55667788);
    check("mid_addr_cleared", {22'b0, mem_addr}, 32'd0);
    req1 = 1'b0;
    rst_n = 1'b1;
    cyc();
    txn(1'b1, 1'b1, 12'h040, 4'b0100, 32'h00990000, lat, we_cnt, we_cyc, rd, other);
    check("reissue_lat", lat, 32'd3);
    check("reissue_word", tb_mem[16], 32'h55997788);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
